biriscv_divider: RTL and testbench

- Iterative RV32M divide/remainder unit; the inverse-arithmetic companion to the pipelined multiplier in the execute cluster.
- Executes DIV, DIVU, REM and REMU with a restoring shift-subtract datapath, one quotient bit per cycle.
- Issue logic stalls on busy_o. The result is returned through a writeback valid/value pair.

---
 rtl/biriscv_divider.sv | 153 +++++++++++++++
 tb/tb_biriscv_divider.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_divider.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle, result on a writeback valid/value pair.
module biriscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            writeback_valid_o,
    output logic [XLEN-1:0] writeback_value_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [5:0]      count_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] dividend_q;
    logic            signed_q;
    logic            rem_sel_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            dbz_q;
    logic            ovf_q;
    logic            busy_q;
    logic            valid_q;
    logic [XLEN-1:0] value_q;

    // Decode: OP major opcode, MULDIV funct7, funct3[2] set selects the divide group
    logic is_div;
    logic op_signed;
    logic op_rem;
    logic accept;
    assign is_div    = (opcode_opcode_i[6:0] == 7'b0110011) &&
                       (opcode_opcode_i[31:25] == 7'b0000001) && opcode_opcode_i[14];
    assign op_signed = ~opcode_opcode_i[12];
    assign op_rem    = opcode_opcode_i[13];
    assign accept    = opcode_valid_i && is_div && (state_q == IDLE) && !flush_i && !hold_i;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    assign a_neg = op_signed & opcode_ra_operand_i[XLEN-1];
    assign b_neg = op_signed & opcode_rb_operand_i[XLEN-1];
    assign a_abs = a_neg ? -opcode_ra_operand_i : opcode_ra_operand_i;
    assign b_abs = b_neg ? -opcode_rb_operand_i : opcode_rb_operand_i;

    // One restoring step: the remainder is always below the divisor, so 33 bits hold the trial difference
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    assign rem_shift = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, divisor_q};
    assign trial_ok  = ~trial[XLEN];

    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] result;
    assign quot_fix = (signed_q && q_neg_q) ? -quot_q : quot_q;
    assign rem_fix  = (signed_q && r_neg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        result = rem_sel_q ? rem_fix : quot_fix;
        if (dbz_q) begin
            result = rem_sel_q ? dividend_q : '1;
        end else if (ovf_q) begin
            result = rem_sel_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7], rem_q[XLEN]};

    // The RUN cycle that finds the counter at zero registers the corrected result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            signed_q   <= 1'b0;
            rem_sel_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            value_q    <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        count_q    <= 6'd32;
                        rem_q      <= '0;
                        quot_q     <= a_abs;
                        divisor_q  <= b_abs;
                        dividend_q <= opcode_ra_operand_i;
                        signed_q   <= op_signed;
                        rem_sel_q  <= op_rem;
                        q_neg_q    <= opcode_ra_operand_i[XLEN-1] ^ opcode_rb_operand_i[XLEN-1];
                        r_neg_q    <= opcode_ra_operand_i[XLEN-1];
                        dbz_q      <= (opcode_rb_operand_i == '0);
                        ovf_q      <= op_signed &&
                                      (opcode_ra_operand_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                                      (opcode_rb_operand_i == '1);
                    end
                end
                RUN: begin
                    if (count_q != 6'd0) begin
                        rem_q   <= trial_ok ? trial : rem_shift;
                        quot_q  <= {quot_q[XLEN-2:0], trial_ok};
                        count_q <= count_q - 6'd1;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        value_q <= result;
                    end
                end
                DONE: begin
                    if (!hold_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign writeback_valid_o = valid_q;
    assign writeback_value_o = value_q;

endmodule

// File: tb/tb_biriscv_divider.sv
// Testbench for biriscv_divider: directed cases, aborts, hold, then randomized ops
// scored against an arithmetic reference model.
module tb_biriscv_divider;

  logic        clk_i;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        hold_i;
  logic        flush_i;
  logic        busy_o;
  logic        writeback_valid_o;
  logic [31:0] writeback_value_o;

  biriscv_divider #(.XLEN(32)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_ra_operand_i (opcode_ra_operand_i),
    .opcode_rb_operand_i (opcode_rb_operand_i),
    .hold_i              (hold_i),
    .flush_i             (flush_i),
    .busy_o              (busy_o),
    .writeback_valid_o   (writeback_valid_o),
    .writeback_value_o   (writeback_value_o)
  );

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // reference model: RV32M rules written as plain arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int  sq;
    bit  ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sq = $signed(a) % $signed(b);
        return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // driver tasks (all start and end on a falling edge)
  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("wait_idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_wb, input logic [31:0] exp);
    wait_idle();
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = enc(f3);
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    @(negedge clk_i);
    opcode_valid_i = 1'b0;
    if (expect_wb) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 33);
    end
  endtask

  // monitor: one pop per rising writeback_valid_o, value and latency checked
  logic prev_v = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (writeback_valid_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_writeback", writeback_value_o, 32'hDEAD_BEEF ^ writeback_value_o);
        end else begin
          logic [31:0] e;
          int          c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("wb_value", writeback_value_o, e);
          check("wb_latency", cyc, c);
        end
      end
      prev_v = writeback_valid_o;
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] v0;
    bit stable;

    rst_i = 1'b0;
    opcode_valid_i = 1'b0;
    opcode_opcode_i = '0;
    opcode_ra_operand_i = '0;
    opcode_rb_operand_i = '0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("reset_value", writeback_value_o, 32'd0);
    rst_i = 1'b1;

    // first op right after reset release, busy length measured
    issue(F_DIVU, 32'd100, 32'd7, 1, 32'd14);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("busy_cycles", n, 34);

    issue(F_REMU, 32'd100, 32'd7, 1, 32'd2);
    issue(F_DIV, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2);
    issue(F_REM, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE);
    issue(F_REM, 32'd100, 32'hFFFF_FFF9, 1, 32'd2);
    issue(F_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    issue(F_REM, 32'd5, 32'd0, 1, 32'd5);
    issue(F_DIVU, 32'h8000_0000, 32'd0, 1, 32'hFFFF_FFFF);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    issue(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);

    // hold across DONE, plus an op presented during RUN that must be dropped
    issue(F_DIVU, 32'd1000, 32'd10, 1, 32'd100);
    repeat (5) @(negedge clk_i);
    opcode_valid_i = 1'b1;
    opcode_opcode_i = enc(F_DIVU);
    opcode_ra_operand_i = 32'd50;
    opcode_rb_operand_i = 32'd5;
    @(negedge clk_i);
    opcode_valid_i = 1'b0;
    n = 0;
    while (!writeback_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    hold_i = 1'b1;
    v0 = writeback_value_o;
    stable = 1'b1;
    n = 0;
    while (writeback_valid_o && n < 10) begin
      n++;
      if (writeback_value_o !== v0) stable = 1'b0;
      if (n == 4) hold_i = 1'b0;
      @(negedge clk_i);
    end
    hold_i = 1'b0;
    check("hold_valid_cycles", n, 4);
    check("hold_value_stable", {31'd0, stable}, 32'd1);
    check("hold_value", v0, 32'd100);

    // flush at RUN cycle 10
    issue(F_DIVU, 32'd77, 32'd5, 0, 32'd0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_valid", {31'd0, writeback_valid_o}, 32'd0);
    issue(F_DIVU, 32'd9, 32'd3, 1, 32'd3);

    // asynchronous reset mid-RUN
    issue(F_DIV, 32'd1000, 32'd7, 0, 32'd0);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy_o}, 32'd0);
    check("areset_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("areset_value", writeback_value_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    issue(F_DIVU, 32'd9, 32'd3, 1, 32'd3);

    // randomized ops, with occasional non-divide words that must be ignored
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        opcode_valid_i = 1'b1;
        opcode_opcode_i = {7'b0000001, 5'd2, 5'd1, 3'($urandom_range(0, 3)), 5'd3, 7'b0110011};
        @(negedge clk_i);
        opcode_valid_i = 1'b0;
        check("nondiv_ignored", {31'd0, busy_o}, 32'd0);
      end
      f3 = 3'(4 + $urandom_range(0, 3));
      a = rand_operand();
      b = rand_operand();
      issue(f3, a, b, 1, ref_model(f3, a, b));
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
